clz_norm_arbiter: RTL and testbench

- Shares one 64-bit count-leading-zeros and normalize unit among NUM_REQ requesters, such as the CORDIC and polynomial stages of the trig pipelines that need a mantissa renormalised.
- Grants requesters round-robin and runs a 2-stage pipeline: stage 1 counts leading zeros, stage 2 left-shifts.
- Returns the normalised value, the shift count and the requester ID on one response channel with valid/ready backpressure.

---
 rtl/clz_norm_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_clz_norm_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clz_norm_arbiter.sv
// ---------------------------------------------------------------------------
// clz_norm_arbiter
//
// Purpose:
//   NUM_REQ requesters share one 64-bit count-leading-zeros and normalise
//   unit. Requesters are granted round-robin. Stage 1 counts leading zeros
//   and stage 2 left-shifts the operand. One response channel returns the
//   normalised value, the shift count, a zero flag and the requester ID, and
//   supports valid/ready backpressure.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   ID_W     requester-ID width, equal to ceil(log2(NUM_REQ))
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   io_req_valid       per-requester request valid
//   io_req_ready       per-requester accept, one-hot or zero
//   io_req_data        operands; requester i drives bits [64*i+63 : 64*i]
//   io_resp_valid      response valid
//   io_resp_ready      downstream accepts the response
//   io_resp_data       operand << shift (MSB set unless the operand was zero)
//   io_resp_shift      leading-zero count (63 for a zero operand)
//   io_resp_zero       operand was all zeros
//   io_resp_id         index of the requester that issued the operand
//
// Optional feature (macro CLZ_NORM_ARB_PERF_EN):
//   io_perf_grants     saturating count of request transfers
//   io_perf_stalls     saturating count of cycles with valid=1 and ready=0
//   io_perf_zero       saturating count of accepted responses with zero=1
// ---------------------------------------------------------------------------
module clz_norm_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     io_req_valid,
    output logic [NUM_REQ-1:0]     io_req_ready,
    input  logic [64*NUM_REQ-1:0]  io_req_data,
    output logic                   io_resp_valid,
    input  logic                   io_resp_ready,
    output logic [63:0]            io_resp_data,
    output logic [5:0]             io_resp_shift,
    output logic                   io_resp_zero,
    output logic [ID_W-1:0]        io_resp_id
`ifdef CLZ_NORM_ARB_PERF_EN
    ,
    output logic [31:0]            io_perf_grants,
    output logic [31:0]            io_perf_stalls,
    output logic [31:0]            io_perf_zero
`endif
);

    // Leading-zero count; an all-zero operand reports 63. Scanning upward
    // lets the highest set bit overwrite any lower one.
    function automatic logic [5:0] lzc64(input logic [63:0] d);
        logic [5:0] n;
        n = 6'd63;
        for (int i = 0; i < 64; i++) begin
            if (d[i]) n = 6'(63 - i);
        end
        return n;
    endfunction

    // Stage 1 register
    logic            s1_valid;
    logic [63:0]     s1_data;
    logic [5:0]      s1_lzc;
    logic [ID_W-1:0] s1_id;

    // Stage 2 register (drives the response outputs directly)
    logic            s2_valid;
    logic [63:0]     s2_data;
    logic [5:0]      s2_lzc;
    logic            s2_zero;
    logic [ID_W-1:0] s2_id;

    // Last granted requester
    logic [ID_W-1:0] rr_ptr;

    logic            s2_load;
    logic            s1_load;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic            transfer;
    logic [63:0]     grant_data;

    // S2 frees up when it is empty or its entry is taken this cycle; S1 can
    // take a new entry when it is empty or its entry moves into S2. This
    // lets a pop and a push happen in the same cycle with no bubble.
    assign s2_load = !s2_valid || io_resp_ready;
    assign s1_load = !s1_valid || s2_load;

    // Round-robin pick: first valid requester upward from rr_ptr+1 with wrap.
    // Walking the offsets from farthest to nearest makes the nearest valid
    // requester the final winner.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (io_req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        io_req_ready = '0;
        if (s1_load && grant_found) io_req_ready[grant_idx] = 1'b1;
    end

    assign transfer   = |io_req_ready;
    assign grant_data = io_req_data[64*int'(grant_idx) +: 64];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr   <= ID_W'(NUM_REQ - 1);   // requester 0 searched first
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_lzc   <= '0;
            s2_zero  <= 1'b0;
            s2_id    <= '0;
        end else begin
            if (transfer) rr_ptr <= grant_idx;

            if (s1_load) s1_valid <= transfer;

            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data << s1_lzc;
                    s2_lzc  <= s1_lzc;
                    s2_zero <= (s1_data == 64'd0);
                    s2_id   <= s1_id;
                end
            end
        end
    end

    // NOTE: the S1 payload has no reset; it is only ever consumed while
    // s1_valid is set, and that flag is reset.
    always_ff @(posedge clock) begin
        if (s1_load && transfer) begin
            s1_data <= grant_data;
            s1_lzc  <= lzc64(grant_data);
            s1_id   <= grant_idx;
        end
    end

    assign io_resp_valid = s2_valid;
    assign io_resp_data  = s2_data;
    assign io_resp_shift = s2_lzc;
    assign io_resp_zero  = s2_zero;
    assign io_resp_id    = s2_id;

`ifdef CLZ_NORM_ARB_PERF_EN
    // Saturating event counters
    always_ff @(posedge clock) begin
        if (reset) begin
            io_perf_grants <= '0;
            io_perf_stalls <= '0;
            io_perf_zero   <= '0;
        end else begin
            if (transfer && io_perf_grants != '1)
                io_perf_grants <= io_perf_grants + 32'd1;
            if (s2_valid && !io_resp_ready && io_perf_stalls != '1)
                io_perf_stalls <= io_perf_stalls + 32'd1;
            if (s2_valid && io_resp_ready && s2_zero && io_perf_zero != '1)
                io_perf_zero <= io_perf_zero + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clz_norm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_clz_norm_arbiter
//
// Self-checking bench for clz_norm_arbiter. A behavioural model tracks the
// in-flight entries as a queue in grant order, picks grants by a plain
// round-robin search, and derives expected responses arithmetically.
// Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_clz_norm_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [64*NUM_REQ-1:0] req_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [63:0]           resp_data;
    logic [5:0]            resp_shift;
    logic                  resp_zero;
    logic [ID_W-1:0]       resp_id;
`ifdef CLZ_NORM_ARB_PERF_EN
    logic [31:0]           perf_grants;
    logic [31:0]           perf_stalls;
    logic [31:0]           perf_zero;
`endif

    always #5 clock = ~clock;

    clz_norm_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (req_valid),
        .io_req_ready  (req_ready),
        .io_req_data   (req_data),
        .io_resp_valid (resp_valid),
        .io_resp_ready (resp_ready),
        .io_resp_data  (resp_data),
        .io_resp_shift (resp_shift),
        .io_resp_zero  (resp_zero),
        .io_resp_id    (resp_id)
`ifdef CLZ_NORM_ARB_PERF_EN
        ,
        .io_perf_grants(perf_grants),
        .io_perf_stalls(perf_stalls),
        .io_perf_zero  (perf_zero)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] data;
        int          id;
        int          edge_no;   // edge at which the request was accepted
    } entry_t;

    entry_t q[$];
    int     last_grant = NUM_REQ - 1;
    int     edge_cnt   = 0;
    int     last_g     = -1;
    int     m_grants   = 0;
    int     m_stalls   = 0;
    int     m_zero     = 0;

    function automatic int leading_zeros(input logic [63:0] d);
        for (int i = 63; i >= 0; i--) begin
            if (d[i]) return 63 - i;
        end
        return 63;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        int i;
        for (int k = 1; k <= NUM_REQ; k++) begin
            i = (last + k) % NUM_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock cycle: inputs are already driven; checks grant and response,
    // crosses the rising edge, updates the model, returns at the falling edge.
    task automatic cycle();
        int          g;
        logic [NUM_REQ-1:0] exp_ready;
        logic        exp_valid;
        logic [63:0] d;
        int          lz;
        #1;
        g = (q.size() < 2 || resp_ready) ? rr_pick(req_valid, last_grant) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        exp_valid = (q.size() > 0) && (edge_cnt >= q[0].edge_no + 1);
        check("resp_valid", 64'(resp_valid), 64'(exp_valid));
        if (exp_valid) begin
            d  = q[0].data;
            lz = leading_zeros(d);
            check("resp_data",  resp_data, d << lz);
            check("resp_shift", 64'(resp_shift), 64'(lz));
            check("resp_zero",  64'(resp_zero), 64'(d == 64'd0));
            check("resp_id",    64'(resp_id), 64'(q[0].id));
        end
        last_g = g;
        @(posedge clock);
        edge_cnt++;
        if (exp_valid && !resp_ready) m_stalls++;
        if (exp_valid && resp_ready) begin
            if (q[0].data == 64'd0) m_zero++;
            void'(q.pop_front());
        end
        if (g >= 0) begin
            q.push_back('{req_data[64*g +: 64], g, edge_cnt});
            last_grant = g;
            m_grants++;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        @(posedge clock);
        @(posedge clock);
        q.delete();
        last_grant = NUM_REQ - 1;
        m_grants   = 0;
        m_stalls   = 0;
        m_zero     = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic single(input int id, input logic [63:0] d);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_data[64*id +: 64] = d;
        resp_ready = 1'b1;
        cycle();
        req_valid = '0;
        cycle();
    endtask

    function automatic logic [63:0] rand64();
        logic [63:0] d;
        d = {$urandom(), $urandom()};
        return d >> $urandom_range(0, 64);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ops[$];

        req_data = '0;
        do_reset();

        // Reset state
        #1;
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_data",  resp_data, 64'd0);
        check("rst_shift", 64'(resp_shift), 64'd0);
        check("rst_zero",  64'(resp_zero), 64'd0);
        check("rst_id",    64'(resp_id), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);

        // Single requests, no backpressure: valid after two edges
        single(2, 64'h0000_0000_0001_0000);
        check("single2_valid", 64'(resp_valid), 64'd1);
        check("single2_data",  resp_data, 64'h8000_0000_0000_0000);
        check("single2_shift", 64'(resp_shift), 64'd47);
        check("single2_zero",  64'(resp_zero), 64'd0);
        check("single2_id",    64'(resp_id), 64'd2);
        idle(1);

        single(1, 64'h8000_0000_0000_0000);
        check("single1_data",  resp_data, 64'h8000_0000_0000_0000);
        check("single1_shift", 64'(resp_shift), 64'd0);
        check("single1_id",    64'(resp_id), 64'd1);
        idle(1);

        // Zero operand
        single(0, 64'd0);
        check("zero_flag",  64'(resp_zero), 64'd1);
        check("zero_shift", 64'(resp_shift), 64'd63);
        check("zero_data",  resp_data, 64'd0);
        check("zero_id",    64'(resp_id), 64'd0);
        idle(2);

        // Round-robin fairness from reset: 0,1,2,3,0,...
        do_reset();
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int k = 0; k < 12; k++) begin
            for (int r = 0; r < NUM_REQ; r++) req_data[64*r +: 64] = rand64();
            #1;
            check("rr_order", 64'(req_ready), 64'd1 << (k % NUM_REQ));
            cycle();
        end
        idle(3);

        // Backpressure: stream 1,2,3 from requester 0 with resp_ready low
        ops = '{64'd1, 64'd2, 64'd3};
        resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req_valid = '0;
            if (ops.size() > 0) begin
                req_valid[0] = 1'b1;
                req_data[63:0] = ops[0];
            end
            cycle();
            if (last_g == 0) void'(ops.pop_front());
        end
        check("bp_ready",  64'(req_ready), 64'd0);
        check("bp_shift",  64'(resp_shift), 64'd63);
        check("bp_data",   resp_data, 64'h8000_0000_0000_0000);
        check("bp_remain", 64'(ops.size()), 64'd1);
        resp_ready = 1'b1;
        while (ops.size() > 0) begin
            req_valid = '0;
            req_valid[0] = 1'b1;
            req_data[63:0] = ops[0];
            cycle();
            if (last_g == 0) void'(ops.pop_front());
        end
        idle(4);
        check("bp_drained", 64'(q.size()), 64'd0);

        // Reset with both stages full
        resp_ready = 1'b0;
        req_valid  = '1;
        for (int c = 0; c < 3; c++) cycle();
        check("mid_full", 64'(q.size()), 64'd2);
        do_reset();
        #1;
        check("mid_rst_valid", 64'(resp_valid), 64'd0);
        req_valid  = 4'b1010;
        resp_ready = 1'b1;
        #1;
        check("mid_rst_grant", 64'(req_ready), 64'b0010);
        cycle();
        idle(3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid  = NUM_REQ'($urandom());
            resp_ready = ($urandom_range(0, 9) < 7);
            for (int r = 0; r < NUM_REQ; r++) begin
                req_data[64*r +: 64] = ($urandom_range(0, 15) == 0) ? 64'd0 : rand64();
            end
            cycle();
        end
        idle(4);
        check("final_drained", 64'(q.size()), 64'd0);

`ifdef CLZ_NORM_ARB_PERF_EN
        check("perf_grants", 64'(perf_grants), 64'(m_grants));
        check("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
        check("perf_zero",   64'(perf_zero),   64'(m_zero));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
